match_event_logger: RTL and testbench

Downstream consumer of the 111010 sequence detector's `y` pulse. Each cycle in which `match` is sampled high, the block time-stamps the event with a free-running cycle counter. It buffers the timestamp in a small first-word-fall-through FIFO and presents it on a valid/ready output port. It also keeps saturating event and drop counters and a sticky overflow flag, for debug readout and for checking detector behaviour on long random streams.

---
 rtl/match_event_logger_if.sv | 28 ++
 rtl/match_event_logger.sv | 129 ++++++++++++
 tb/tb_match_event_logger.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/match_event_logger_if.sv
// Output stream of the match event logger: a valid/ready port that carries one timestamp per
// transfer.
//   out_valid : the producer holds an entry
//   out_ready : the consumer accepts the entry on this rising edge
//   out_ts    : timestamp of the entry at the head of the FIFO (zero while out_valid is low)
interface match_event_logger_if #(
  parameter int unsigned TS_W = 16
) ();

  logic            out_valid;
  logic            out_ready;
  logic [TS_W-1:0] out_ts;

  // Producer side (the logger).
  modport master (
    output out_valid,
    output out_ts,
    input  out_ready
  );

  // Consumer side (downstream logic or a testbench).
  modport slave (
    input  out_valid,
    input  out_ts,
    output out_ready
  );

endinterface

// File: rtl/match_event_logger.sv
// Match event logger. The block time-stamps every cycle in which the sequence detector's match
// pulse is high. Each timestamp is buffered in a first-word-fall-through FIFO and offered on a
// valid/ready stream. The block also keeps saturating event and drop counters and a sticky
// overflow flag for debug readout.
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   match      : detector output; each high cycle is one event
//   clr        : synchronous clear of total_cnt, drop_cnt and overflow
//   out_if     : output stream (out_valid / out_ready / out_ts)
//   level      : current FIFO occupancy
//   total_cnt  : saturating count of all events
//   drop_cnt   : saturating count of events lost to a full FIFO
//   overflow   : sticky, set by the first drop
module match_event_logger #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4,   // power of two, >= 2
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     match,
  input  logic                     clr,
  match_event_logger_if.master     out_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             overflow_q, overflow_d;

  logic valid;
  logic full;
  logic pop;
  logic push_acc;
  logic drop;

  assign valid = (level_q != '0);
  assign full  = (level_q == LvlW'(DEPTH));
  assign pop   = valid & out_if.out_ready;
  // When the FIFO is full, a push is accepted only if a pop frees the head slot on the same edge.
  // In that case wr_ptr equals rd_ptr, so the new entry lands in the slot that is leaving.
  assign push_acc = match & (~full | pop);
  assign drop     = match & full & ~pop;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    total_d    = total_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;

    if (push_acc) begin
      mem_d[wr_ptr_q] = ts_q;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push_acc, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    // The clear takes priority over an increment on the same edge. The FIFO path is unaffected.
    if (clr) begin
      total_d    = '0;
      drop_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (match && (total_q != '1)) begin
        total_d = total_q + CNT_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      total_q    <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      total_q    <= total_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // All outputs are decoded from registers only.
  assign out_if.out_valid = valid;
  assign out_if.out_ts    = valid ? mem_q[rd_ptr_q] : '0;
  assign level            = level_q;
  assign total_cnt        = total_q;
  assign drop_cnt         = drop_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_match_event_logger.sv
module tb_match_event_logger;

  logic       clk;
  logic       rst;
  logic       match;
  logic       clr;
  logic [2:0] level;
  logic [7:0] total_cnt;
  logic [7:0] drop_cnt;
  logic       overflow;

  int n_chk;
  int n_bad;
  int cyc;     // rising edges since the last reset release; equals the DUT's ts (mod 2^16)
  int base;
  int t0;

  match_event_logger_if #(.TS_W(16)) out_if ();

  match_event_logger #(
    .TS_W  (16),
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .match     (match),
    .clr       (clr),
    .out_if    (out_if),
    .level     (level),
    .total_cnt (total_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    match            = 1'b0;
    clr              = 1'b0;
    out_if.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    n_chk            = 0;
    n_bad            = 0;
    cyc              = 0;
    rst              = 1'b0;
    match            = 1'b0;
    clr              = 1'b0;
    out_if.out_ready = 1'b0;
    #12;

    // Idle after reset.
    do_reset();
    repeat (10) tick();
    check_eq("idle_valid", 32'(out_if.out_valid), 0);
    check_eq("idle_ts_out", 32'(out_if.out_ts), 0);
    check_eq("idle_level", 32'(level), 0);
    check_eq("idle_total", 32'(total_cnt), 0);
    check_eq("idle_drop", 32'(drop_cnt), 0);
    check_eq("idle_ovf", 32'(overflow), 0);
    check_eq("idle_ts_int", 32'(dut.ts_q), 10);

    // A single pulse on the edge where ts=5, then one pop.
    do_reset();
    repeat (5) tick();
    match = 1'b1;
    tick();
    match = 1'b0;
    check_eq("single_valid", 32'(out_if.out_valid), 1);
    check_eq("single_ts", 32'(out_if.out_ts), 5);
    check_eq("single_level", 32'(level), 1);
    check_eq("single_total", 32'(total_cnt), 1);
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
    check_eq("single_pop_valid", 32'(out_if.out_valid), 0);
    check_eq("single_pop_level", 32'(level), 0);
    check_eq("single_pop_ts", 32'(out_if.out_ts), 0);

    // Six events at ts=20..25 into a 4-deep FIFO: the last two are dropped.
    do_reset();
    repeat (20) tick();
    match = 1'b1;
    repeat (6) tick();
    match = 1'b0;
    check_eq("ovf_level", 32'(level), 4);
    check_eq("ovf_drop", 32'(drop_cnt), 2);
    check_eq("ovf_flag", 32'(overflow), 1);
    check_eq("ovf_total", 32'(total_cnt), 6);
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", 32'(out_if.out_valid), 1);
      check_eq("drain_ts", 32'(out_if.out_ts), 32'(20 + i));
      tick();
    end
    out_if.out_ready = 1'b0;
    check_eq("drain_empty", 32'(out_if.out_valid), 0);

    // Fill the FIFO, then push and pop together for three edges: nothing is dropped.
    base  = cyc;
    match = 1'b1;
    repeat (4) tick();
    check_eq("full_level", 32'(level), 4);
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("full_pp_ts", 32'(out_if.out_ts), 32'(base + i));
      tick();
      check_eq("full_pp_level", 32'(level), 4);
    end
    match = 1'b0;
    check_eq("full_pp_drop", 32'(drop_cnt), 2);
    for (int i = 0; i < 4; i++) begin
      check_eq("full_drain_ts", 32'(out_if.out_ts), 32'(base + 3 + i));
      tick();
    end
    check_eq("full_drain_level", 32'(level), 0);

    // Clear the counters, then saturate total_cnt.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_total", 32'(total_cnt), 0);
    check_eq("clr_drop", 32'(drop_cnt), 0);
    check_eq("clr_ovf", 32'(overflow), 0);
    t0    = cyc;
    match = 1'b1;
    repeat (300) tick();
    check_eq("sat_total", 32'(total_cnt), 255);
    check_eq("sat_drop", 32'(drop_cnt), 0);
    check_eq("sat_level", 32'(level), 1);
    check_eq("sat_head", 32'(out_if.out_ts), 32'(t0 + 299));
    // A clear together with a match: the counter clears but the event is still buffered.
    out_if.out_ready = 1'b0;
    clr              = 1'b1;
    tick();
    clr   = 1'b0;
    match = 1'b0;
    check_eq("clrm_total", 32'(total_cnt), 0);
    check_eq("clrm_ovf", 32'(overflow), 0);
    check_eq("clrm_level", 32'(level), 2);
    out_if.out_ready = 1'b1;
    tick();
    check_eq("clrm_entry", 32'(out_if.out_ts), 32'(t0 + 300));
    tick();
    out_if.out_ready = 1'b0;
    check_eq("clrm_empty", 32'(out_if.out_valid), 0);

    // Timestamp wrap: events at ts=65535 and ts=0.
    while (cyc < 65535) tick();
    match = 1'b1;
    repeat (2) tick();
    check_eq("wrap_level", 32'(level), 2);
    check_eq("wrap_head0", 32'(out_if.out_ts), 65535);
    out_if.out_ready = 1'b1;
    tick();
    match            = 1'b0;
    out_if.out_ready = 1'b0;
    check_eq("wrap_head1", 32'(out_if.out_ts), 0);
    check_eq("wrap_level2", 32'(level), 2);
    check_eq("wrap_total", 32'(total_cnt), 3);

    // Asynchronous reset between edges takes effect at once.
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_if.out_valid), 0);
    check_eq("arst_ts_out", 32'(out_if.out_ts), 0);
    check_eq("arst_level", 32'(level), 0);
    check_eq("arst_total", 32'(total_cnt), 0);
    check_eq("arst_ts_int", 32'(dut.ts_q), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    repeat (3) tick();
    check_eq("post_rst_valid", 32'(out_if.out_valid), 0);
    check_eq("post_rst_ts_int", 32'(dut.ts_q), 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
